// File: rtl/reg_file.sv
// Architectural register file: 2^ADDR_WIDTH x DATA_WIDTH, two combinational read ports,
// one synchronous write port, x0 hard-wired to zero, registered mirror of register A0_INDEX.
`timescale 1ns/1ps

module reg_file #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 5,
    parameter bit          BYPASS     = 1'b1,
    parameter int unsigned A0_INDEX   = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] AD1,
    input  logic [ADDR_WIDTH-1:0] AD2,
    input  logic [ADDR_WIDTH-1:0] AD3,
    input  logic                  WE3,
    input  logic [DATA_WIDTH-1:0] WD3,
    output logic [DATA_WIDTH-1:0] RD1,
    output logic [DATA_WIDTH-1:0] RD2,
    output logic [DATA_WIDTH-1:0] a0
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    // Register 0 has no storage; the array starts at index 1.
    logic [DATA_WIDTH-1:0] r_regs [1:DEPTH-1];
    logic [DATA_WIDTH-1:0] r_a0;
    logic [DATA_WIDTH-1:0] w_a0_next;
    logic [DATA_WIDTH-1:0] w_rd1;
    logic [DATA_WIDTH-1:0] w_rd2;
    logic                  w_wr_en;

    assign w_wr_en = WE3 && (AD3 != '0);

    for (genvar g = 1; g < DEPTH; g++) begin : g_reg
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_regs[g] <= '0;
            end else if (w_wr_en && (AD3 == ADDR_WIDTH'(g))) begin
                r_regs[g] <= WD3;
            end
        end
    end

    always_comb begin
        w_rd1 = '0;
        if (AD1 != '0) begin
            w_rd1 = r_regs[AD1];
            if (BYPASS && w_wr_en && (AD3 == AD1)) begin
                w_rd1 = WD3;
            end
        end
    end

    always_comb begin
        w_rd2 = '0;
        if (AD2 != '0) begin
            w_rd2 = r_regs[AD2];
            if (BYPASS && w_wr_en && (AD3 == AD2)) begin
                w_rd2 = WD3;
            end
        end
    end

    // a0 loads the post-write value so it tracks the stored register with no extra cycle.
    if ((A0_INDEX == 0) || (A0_INDEX >= DEPTH)) begin : g_a0_zero
        assign w_a0_next = '0;
    end else begin : g_a0_reg
        localparam logic [ADDR_WIDTH-1:0] A0_ADDR = ADDR_WIDTH'(A0_INDEX);
        always_comb begin
            w_a0_next = r_regs[A0_INDEX];
            if (w_wr_en && (AD3 == A0_ADDR)) begin
                w_a0_next = WD3;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a0 <= '0;
        end else begin
            r_a0 <= w_a0_next;
        end
    end

    assign RD1 = w_rd1;
    assign RD2 = w_rd2;
    assign a0  = r_a0;

endmodule

// File: tb/tb_reg_file.sv
// Randomized self-checking bench for reg_file: a bypassing and a non-bypassing instance
// share stimulus and are compared against an array-based reference model.
`timescale 1ns/1ps

module tb_reg_file;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  ad1, ad2, ad3;
    logic        we3;
    logic [31:0] wd3;
    logic [31:0] rd1_b, rd2_b, a0_b;
    logic [31:0] rd1_n, rd2_n, a0_n;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] model [32];
    logic [31:0] model_a0;

    always #5 clk = ~clk;

    reg_file #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(5),
        .BYPASS    (1'b1),
        .A0_INDEX  (10)
    ) u_dut_byp (
        .clk  (clk),
        .rst_n(rst_n),
        .AD1  (ad1),
        .AD2  (ad2),
        .AD3  (ad3),
        .WE3  (we3),
        .WD3  (wd3),
        .RD1  (rd1_b),
        .RD2  (rd2_b),
        .a0   (a0_b)
    );

    reg_file #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(5),
        .BYPASS    (1'b0),
        .A0_INDEX  (10)
    ) u_dut_nob (
        .clk  (clk),
        .rst_n(rst_n),
        .AD1  (ad1),
        .AD2  (ad2),
        .AD3  (ad3),
        .WE3  (we3),
        .WD3  (wd3),
        .RD1  (rd1_n),
        .RD2  (rd2_n),
        .a0   (a0_n)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Expected read value: x0 is zero; a pending write forwards only when bypassing.
    function automatic logic [31:0] exp_rd(input bit byp, input logic [4:0] ad);
        if (ad == 5'd0) return 32'h0;
        if (byp && we3 && (ad3 != 5'd0) && (ad3 == ad)) return wd3;
        return model[ad];
    endfunction

    task automatic check_reads(input string phase);
        check({phase, "_rd1_byp"}, rd1_b, exp_rd(1'b1, ad1));
        check({phase, "_rd2_byp"}, rd2_b, exp_rd(1'b1, ad2));
        check({phase, "_rd1_nob"}, rd1_n, exp_rd(1'b0, ad1));
        check({phase, "_rd2_nob"}, rd2_n, exp_rd(1'b0, ad2));
    endtask

    task automatic check_a0(input string phase);
        check({phase, "_a0_byp"}, a0_b, model_a0);
        check({phase, "_a0_nob"}, a0_n, model_a0);
    endtask

    task automatic cycle(input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] a3,
                         input logic we, input logic [31:0] wd);
        @(negedge clk);
        ad1 = a1; ad2 = a2; ad3 = a3; we3 = we; wd3 = wd;
        #1;
        check_reads("pre");
        @(posedge clk);
        if (we && (a3 != 5'd0)) model[a3] = wd;
        model_a0 = model[10];
        #1;
        check_reads("post");
        check_a0("post");
    endtask

    // Reset asserted between edges; a write presented during reset must be discarded.
    task automatic do_reset();
        @(negedge clk);
        we3 = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
        model_a0 = 32'h0;
        check_reads("rst");
        check_a0("rst");
        ad3 = ad1; we3 = 1'b1; wd3 = 32'h0000_1234;
        @(posedge clk);
        #1;
        we3 = 1'b0;
        #1;
        check_reads("rst_wr");
        check_a0("rst_wr");
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b1;
        ad1 = '0; ad2 = '0; ad3 = '0; we3 = 1'b0; wd3 = '0;
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
        model_a0 = 32'h0;

        do_reset();

        // Basic write/read and unwritten register
        cycle(5'd3, 5'd3, 5'd3, 1'b1, 32'h0000_0007);
        cycle(5'd3, 5'd3, 5'd0, 1'b0, 32'h0);
        check("basic_rd1", rd1_b, 32'h7);
        check("basic_rd2", rd2_n, 32'h7);
        cycle(5'd4, 5'd3, 5'd0, 1'b0, 32'h0);
        check("unwritten_x4", rd1_b, 32'h0);

        // x0 protection, including forwarding attempt in the write cycle
        cycle(5'd0, 5'd0, 5'd0, 1'b1, 32'hFFFF_FFFF);
        check("x0_rd1", rd1_b, 32'h0);

        // Bypass vs stored-value read
        cycle(5'd7, 5'd7, 5'd7, 1'b1, 32'h11);
        @(negedge clk);
        ad1 = 5'd7; ad2 = 5'd7; ad3 = 5'd7; we3 = 1'b1; wd3 = 32'h22;
        #1;
        check("bypass_pre_byp", rd1_b, 32'h22);
        check("bypass_pre_nob", rd1_n, 32'h11);
        @(posedge clk);
        model[7] = 32'h22;
        #1;
        check("bypass_post_nob", rd1_n, 32'h22);

        // a0 mirror
        cycle(5'd10, 5'd0, 5'd10, 1'b1, 32'h0000_002A);
        check("a0_load", a0_b, 32'h2A);
        cycle(5'd11, 5'd10, 5'd11, 1'b1, 32'h99);
        check("a0_hold", a0_n, 32'h2A);

        // WE3 gating and last-write-wins
        cycle(5'd2, 5'd2, 5'd2, 1'b0, 32'h55);
        cycle(5'd2, 5'd2, 5'd0, 1'b0, 32'h0);
        check("we_gate_x2", rd1_n, 32'h0);
        cycle(5'd2, 5'd2, 5'd2, 1'b1, 32'h1);
        cycle(5'd2, 5'd2, 5'd2, 1'b1, 32'h2);
        cycle(5'd2, 5'd2, 5'd0, 1'b0, 32'h0);
        check("last_wins_x2", rd2_b, 32'h2);

        // Reset after populated state, including a0
        cycle(5'd5, 5'd10, 5'd5, 1'b1, 32'hDEAD_BEEF);
        @(negedge clk);
        ad1 = 5'd5; ad2 = 5'd10;
        do_reset();

        // Randomized traffic; narrow address range half the time to force collisions
        for (int n = 0; n < 600; n++) begin
            logic [4:0] a1, a2, a3;
            if ($urandom_range(0, 1) == 0) begin
                a1 = 5'($urandom_range(0, 11));
                a2 = 5'($urandom_range(0, 11));
                a3 = 5'($urandom_range(0, 11));
            end else begin
                a1 = 5'($urandom);
                a2 = 5'($urandom);
                a3 = 5'($urandom);
            end
            if ($urandom_range(0, 3) == 0) a3 = a1;
            cycle(a1, a2, a3, 1'($urandom_range(0, 3) != 0), $urandom);
            if ($urandom_range(0, 99) == 0) do_reset();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
